bit_stream_checker: RTL and testbench

Receive-side companion to our stimulus generators: samples a serial bit `D` on every rising `clk` and locks onto a periodic square-wave pattern of `RUN_LEN` cycles per level. Once locked, it free-runs a local copy of the pattern, compares every sample, and reports mismatches and totals. It sits at the far end of a serial data path (DUT output or link) as a self-checking monitor.

---
 rtl/bit_check_pkg.sv | 18 +
 rtl/run_meter.sv | 48 ++++
 rtl/bit_stream_checker.sv | 130 +++++++++++++
 tb/tb_bit_stream_checker.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bit_check_pkg.sv
// rtl/bit_check_pkg.sv - shared types and helpers for bit_stream_checker
package bit_check_pkg;

  typedef enum logic {
    S_SEARCH = 1'b0,
    S_LOCKED = 1'b1
  } state_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
    return (v >= max_v) ? v : v + 32'd1;
  endfunction

  // Register width able to hold 0..max_v, never narrower than one bit.
  function automatic int bits_for(input int max_v);
    return (max_v < 2) ? 1 : $clog2(max_v + 1);
  endfunction

endpackage

// File: rtl/run_meter.sv
// rtl/run_meter.sv - run-length counter with transition detect
// Measures how long the sampled stream has held its level while searching for lock.
module run_meter
  import bit_check_pkg::*;
#(
  parameter int RUN_LEN = 1,
  parameter int RUN_W   = bits_for(RUN_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             d_q,
  input  logic             en,
  input  logic             clr_first,
  output logic             trans,
  output logic             first,
  output logic [RUN_W-1:0] run
);

  logic d_prev;
  logic seen;

  assign trans = (d_q != d_prev);
  assign first = trans && !seen;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_prev <= 1'b0;
      seen   <= 1'b0;
      run    <= RUN_W'(1);
    end else begin
      d_prev <= d_q;
      if (clr_first) begin
        seen <= 1'b0;
      end else if (en && trans) begin
        seen <= 1'b1;
      end
      // Run saturates one past RUN_LEN so an over-long level never scores as good.
      if (en) begin
        if (trans) begin
          run <= RUN_W'(1);
        end else begin
          run <= RUN_W'(sat_inc(32'(run), 32'(RUN_LEN + 1)));
        end
      end
    end
  end

endmodule

// File: rtl/bit_stream_checker.sv
// rtl/bit_stream_checker.sv - locks onto a square-wave bit pattern and counts mismatches
// Search FSM scores run lengths; once locked a local pattern copy is compared every cycle.
module bit_stream_checker
  import bit_check_pkg::*;
#(
  parameter int RUN_LEN     = 1,
  parameter int LOCK_RUNS   = 4,
  parameter int UNLOCK_ERRS = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             D,
  output logic             Q,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] bit_cnt
);

  localparam int RUN_W  = bits_for(RUN_LEN + 1);
  localparam int GOOD_W = bits_for(LOCK_RUNS);
  localparam int PH_W   = bits_for(RUN_LEN);
  localparam int CERR_W = bits_for(UNLOCK_ERRS);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [CERR_W-1:0] CERR_MAX = '1;

  state_t            state;
  logic              d_q;
  logic              exp_bit;
  logic              trans;
  logic              first;
  logic [RUN_W-1:0]  run;
  logic [GOOD_W-1:0] good;
  logic [PH_W-1:0]   ph;
  logic [CERR_W-1:0] cerr;
  logic              mismatch;
  logic              run_ok;
  logic              unlock_now;

  assign Q = d_q;

  always_comb begin
    mismatch   = (d_q != exp_bit);
    run_ok     = (int'(run) == RUN_LEN);
    unlock_now = (state == S_LOCKED) && (UNLOCK_ERRS != 0) && mismatch &&
                 (int'(cerr) + 1 == UNLOCK_ERRS);
  end

  run_meter #(
    .RUN_LEN (RUN_LEN),
    .RUN_W   (RUN_W)
  ) u_run_meter (
    .clk       (clk),
    .rst_n     (rst_n),
    .d_q       (d_q),
    .en        (state == S_SEARCH),
    .clr_first (unlock_now),
    .trans     (trans),
    .first     (first),
    .run       (run)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q <= 1'b0;
    end else begin
      d_q <= D;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_SEARCH;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_cnt   <= '0;
      bit_cnt   <= '0;
      good      <= '0;
      exp_bit   <= 1'b0;
      ph        <= PH_W'(1);
      cerr      <= '0;
    end else begin
      err_pulse <= 1'b0;
      case (state)
        S_SEARCH: begin
          if (trans) begin
            if (first || !run_ok) begin
              good <= '0;
            end else if (int'(good) + 1 == LOCK_RUNS) begin
              // d_q is the first sample of a fresh run; seed the pattern for the next sample.
              state   <= S_LOCKED;
              locked  <= 1'b1;
              good    <= '0;
              cerr    <= '0;
              exp_bit <= (RUN_LEN == 1) ? ~d_q : d_q;
              ph      <= (RUN_LEN == 1) ? PH_W'(1) : PH_W'(2);
            end else begin
              good <= good + GOOD_W'(1);
            end
          end
        end
        S_LOCKED: begin
          bit_cnt <= CNT_W'(sat_inc(32'(bit_cnt), 32'(CNT_MAX)));
          if (mismatch) begin
            err_pulse <= 1'b1;
            err_cnt   <= CNT_W'(sat_inc(32'(err_cnt), 32'(CNT_MAX)));
            cerr      <= CERR_W'(sat_inc(32'(cerr), 32'(CERR_MAX)));
          end else begin
            cerr <= '0;
          end
          if (int'(ph) == RUN_LEN) begin
            exp_bit <= ~exp_bit;
            ph      <= PH_W'(1);
          end else begin
            ph <= ph + PH_W'(1);
          end
          if (unlock_now) begin
            state  <= S_SEARCH;
            locked <= 1'b0;
            cerr   <= '0;
            good   <= '0;
          end
        end
        default: state <= S_SEARCH;
      endcase
    end
  end

endmodule

// File: tb/tb_bit_stream_checker.sv
// tb/tb_bit_stream_checker.sv - randomized self-checking bench for bit_stream_checker
module tb_bit_stream_checker;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic d0, d1, d2;
  logic q0, l0, e0;
  logic q1, l1, e1;
  logic q2, l2, e2;
  logic [15:0] ec0, bc0, ec1, bc1;
  logic [3:0]  ec2, bc2;

  bit_stream_checker u0 (
    .clk(clk), .rst_n(rst_n), .D(d0), .Q(q0), .locked(l0),
    .err_pulse(e0), .err_cnt(ec0), .bit_cnt(bc0)
  );

  bit_stream_checker #(.RUN_LEN(3)) u1 (
    .clk(clk), .rst_n(rst_n), .D(d1), .Q(q1), .locked(l1),
    .err_pulse(e1), .err_cnt(ec1), .bit_cnt(bc1)
  );

  bit_stream_checker #(.UNLOCK_ERRS(0), .CNT_W(4)) u2 (
    .clk(clk), .rst_n(rst_n), .D(d2), .Q(q2), .locked(l2),
    .err_pulse(e2), .err_cnt(ec2), .bit_cnt(bc2)
  );

  typedef struct packed {
    int rl; int lr; int ue; int cmax;
    bit dq; bit dprev; bit seen; bit locked; bit expb; bit ep;
    int run; int good; int ph; int cerr; int ec; int bc;
  } mdl_t;

  mdl_t m0, m1, m2;
  int errors = 0;
  int checks = 0;

  bit n0, n2, lv1, skip0, inv0, hold2;
  int c1, len1, noisy, str_hit, pulses;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, req);
    end
  endtask

  function automatic mdl_t m_reset(input int rl, input int lr, input int ue, input int cw);
    mdl_t m;
    m = '0;
    m.rl = rl; m.lr = lr; m.ue = ue; m.cmax = (1 << cw) - 1;
    m.run = 1; m.ph = 1;
    return m;
  endfunction

  // One clock edge of the spec rules: search scores runs, locked compares against the pattern.
  function automatic mdl_t m_step(input mdl_t m, input bit d);
    mdl_t n;
    n = m;
    n.ep = 1'b0;
    if (!m.locked) begin
      if (m.dq != m.dprev) begin
        if (!m.seen) begin
          n.seen = 1'b1;
          n.good = 0;
        end else begin
          n.good = (m.run == m.rl) ? m.good + 1 : 0;
          if (n.good == m.lr) begin
            n.locked = 1'b1;
            n.good   = 0;
            n.cerr   = 0;
            n.expb   = (m.rl == 1) ? !m.dq : m.dq;
            n.ph     = (m.rl == 1) ? 1 : 2;
          end
        end
        n.run = 1;
      end else if (m.run < m.rl + 1) begin
        n.run = m.run + 1;
      end
    end else begin
      n.ep = (m.dq != m.expb);
      if (m.bc < m.cmax) n.bc = m.bc + 1;
      if (n.ep) begin
        if (m.ec < m.cmax) n.ec = m.ec + 1;
        n.cerr = m.cerr + 1;
      end else begin
        n.cerr = 0;
      end
      if (m.ph == m.rl) begin
        n.expb = !m.expb;
        n.ph   = 1;
      end else begin
        n.ph = m.ph + 1;
      end
      if (m.ue != 0 && n.cerr == m.ue) begin
        n.locked = 1'b0;
        n.good   = 0;
        n.cerr   = 0;
        n.seen   = 1'b0;
      end
    end
    n.dprev = m.dq;
    n.dq    = d;
    return n;
  endfunction

  task automatic cmp(input string nm, input mdl_t m, input logic q, input logic l, input logic e,
                     input logic [31:0] ec, input logic [31:0] bc);
    check_val({nm, "_q"},      32'(q),  32'(m.dq));
    check_val({nm, "_locked"}, 32'(l),  32'(m.locked));
    check_val({nm, "_pulse"},  32'(e),  32'(m.ep));
    check_val({nm, "_errcnt"}, ec,      32'(m.ec));
    check_val({nm, "_bitcnt"}, bc,      32'(m.bc));
  endtask

  task automatic cmp_all();
    cmp("u0", m0, q0, l0, e0, 32'(ec0), 32'(bc0));
    cmp("u1", m1, q1, l1, e1, 32'(ec1), 32'(bc1));
    cmp("u2", m2, q2, l2, e2, 32'(ec2), 32'(bc2));
  endtask

  task automatic drive();
    if (skip0) skip0 = 1'b0;
    else n0 = ~n0;
    d0 = n0;
    if (inv0) begin
      d0   = ~n0;
      inv0 = 1'b0;
    end
    if (!hold2) n2 = ~n2;
    d2 = n2;
    if (len1 == 4 && c1 == 3) str_hit = 1;
    d1 = lv1;
    c1++;
    if (c1 >= len1) begin
      lv1  = ~lv1;
      c1   = 0;
      len1 = 3;
    end
    if (noisy == 1) begin
      if ($urandom_range(0, 11) == 0) d0 = ~d0;
      if ($urandom_range(0, 11) == 0) d1 = ~d1;
      if ($urandom_range(0, 3) == 0)  d2 = ~d2;
    end else if (noisy == 2) begin
      d0 = 1'($urandom_range(0, 1));
      d1 = 1'($urandom_range(0, 1));
      d2 = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic step();
    drive();
    @(posedge clk);
    m0 = m_step(m0, d0);
    m1 = m_step(m1, d1);
    m2 = m_step(m2, d2);
    @(negedge clk);
    cmp_all();
  endtask

  task automatic restart_patterns();
    n0 = 1'b0; n2 = 1'b0; lv1 = 1'b1; c1 = 0; len1 = 3;
    skip0 = 1'b0; inv0 = 1'b0; hold2 = 1'b0; noisy = 0;
    m0 = m_reset(1, 4, 4, 16);
    m1 = m_reset(3, 4, 4, 16);
    m2 = m_reset(1, 4, 0, 4);
  endtask

  task automatic lock_from_release(input string nm);
    for (int i = 1; i <= 6; i++) begin
      step();
      if (i == 5) check_val({nm, "_lock_e5"}, 32'(l0), 32'd0);
      if (i == 6) check_val({nm, "_lock_e6"}, 32'(l0), 32'd1);
    end
    check_val({nm, "_bc_at_lock"}, 32'(bc0), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    d0 = 1'b0; d1 = 1'b0; d2 = 1'b0;
    str_hit = 0; pulses = 0;
    restart_patterns();
    repeat (3) @(negedge clk);
    cmp_all();
    rst_n = 1'b1;

    // Clean patterns from release
    lock_from_release("first");
    repeat (100) step();
    check_val("clean_bc100", 32'(bc0), 32'd100);
    check_val("clean_ec0",   32'(ec0), 32'd0);
    check_val("rl3_locked",  32'(l1),  32'd1);
    check_val("rl3_ec0",     32'(ec1), 32'd0);

    // Skipped toggle on u0: four errors, unlock, relock after five transitions
    skip0 = 1'b1;
    step();
    check_val("skip_k_pulse", 32'(e0), 32'd0);
    for (int j = 1; j <= 4; j++) begin
      step();
      check_val("skip_pulse",  32'(e0), 32'd1);
      check_val("skip_locked", 32'(l0), (j < 4) ? 32'd1 : 32'd0);
    end
    check_val("skip_ec4", 32'(ec0), 32'd4);
    for (int j = 1; j <= 5; j++) begin
      step();
      check_val("relock", 32'(l0), (j == 5) ? 32'd1 : 32'd0);
    end

    // Stretched level on the RUN_LEN=3 checker
    len1 = 4;
    str_hit = 0;
    for (int j = 0; j < 8 && str_hit == 0; j++) step();
    check_val("stretch_hit",   32'(str_hit), 32'd1);
    check_val("stretch_k0",    32'(e1), 32'd0);
    step();
    check_val("stretch_k1",    32'(e1), 32'd1);

    // Single inverted bit on u0 while u2 sees a constant input
    repeat (10) step();
    inv0  = 1'b1;
    hold2 = 1'b1;
    for (int j = 0; j < 40; j++) begin
      step();
      if (e0) pulses++;
    end
    hold2 = 1'b0;
    check_val("inv_pulses", 32'(pulses), 32'd1);
    check_val("inv_ec",     32'(ec0),    32'd5);
    check_val("inv_locked", 32'(l0),     32'd1);
    check_val("sat_ec15",   32'(ec2),    32'd15);
    check_val("sat_locked", 32'(l2),     32'd1);

    // Randomized glitches, then fully random data
    noisy = 1;
    repeat (200) step();
    noisy = 2;
    repeat (150) step();
    noisy = 0;
    repeat (30) step();
    check_val("resync_locked", 32'(l0), 32'd1);

    // Asynchronous reset mid-stream
    #2 rst_n = 1'b0;
    #1;
    check_val("rst_locked", 32'(l0),  32'd0);
    check_val("rst_ec",     32'(ec0), 32'd0);
    check_val("rst_bc",     32'(bc0), 32'd0);
    check_val("rst_q",      32'(q0),  32'd0);
    restart_patterns();
    @(negedge clk);
    cmp_all();
    rst_n = 1'b1;
    lock_from_release("again");
    repeat (20) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
